mips_multicycle_ctrl: RTL and testbench

- Multicycle MIPS control unit, directly upstream of the 32x32 register file.
- Holds the instruction register (IR) and drives rs/rt/write_reg/reg_write into the register file.
- Drives every datapath strobe: PC, memory, ALU operand muxes, ALU control.
- Register file reads on negedge, so rs/rt stay stable for whole cycles after the IR loads.

---
 rtl/mips_multicycle_ctrl_pkg.sv | 52 +++++
 rtl/mips_multicycle_ctrl_alu_decoder.sv | 41 ++++
 rtl/mips_multicycle_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared opcode/funct/ALU-control constants and the state encoding for the
// multicycle MIPS control unit.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // Coarse ALU intent from the FSM; the decoder refines it into alu_ctrl.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_IMMEXEC = 4'd10,
        S_IMMWB   = 4'd11
    } state_t;

    function automatic logic is_imm_op(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// Combinational ALU control decoder: maps the FSM's coarse alu_op plus the
// instruction funct/opcode onto a 4-bit alu_ctrl code.
module mips_alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    input  logic [5:0] opcode,
    output logic [3:0] alu_ctrl,
    output logic       funct_illegal
);

    always_comb begin
        alu_ctrl      = ALU_ADD;
        funct_illegal = 1'b0;
        case (alu_op)
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: funct_illegal = 1'b1;
                endcase
            end
            // Legality of immediate opcodes is decided by the FSM, not here.
            ALUOP_IMM: begin
                case (opcode)
                    OP_ANDI: alu_ctrl = ALU_AND;
                    OP_ORI:  alu_ctrl = ALU_OR;
                    OP_SLTI: alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: IR, Moore FSM and all datapath strobes.
// Define MIPS_CTRL_IMM_OPS_EN to add addi/andi/ori/slti support.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int RF_ADDR_W = 5,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_W-1:0]    mem_rdata,
    input  logic                 alu_zero,
    output logic [RF_ADDR_W-1:0] rs,
    output logic [RF_ADDR_W-1:0] rt,
    output logic [RF_ADDR_W-1:0] write_reg,
    output logic                 reg_write,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic                 pc_en,
    output logic [1:0]           pc_src,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 mem_to_reg,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [3:0]           alu_ctrl,
    output logic                 illegal,
    output logic [3:0]           state_o
);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] ir;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic              ir_unused;

    logic [1:0] alu_op;
    logic [3:0] dec_alu_ctrl;
    logic       funct_illegal;

    logic       c_reg_write, c_pc_write, c_pc_write_cond, c_i_or_d;
    logic       c_mem_read, c_mem_write, c_ir_write, c_mem_to_reg;
    logic       c_alu_src_a, c_illegal;
    logic [1:0] c_pc_src, c_alu_src_b;

    assign opcode    = ir[31:26];
    assign funct     = ir[5:0];
    assign ir_unused = ^ir[10:6];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH) ir <= mem_rdata;
        end
    end

    // Kept apart from the main decode so funct_illegal never feeds back into alu_op.
    always_comb begin
        alu_op = ALUOP_ADD;
        case (state)
            S_EXEC:             alu_op = ALUOP_FUNCT;
            S_BRANCH:           alu_op = ALUOP_SUB;
            S_IMMEXEC, S_IMMWB: alu_op = ALUOP_IMM;
            default:            alu_op = ALUOP_ADD;
        endcase
    end

    mips_alu_decoder u_alu_decoder (
        .alu_op        (alu_op),
        .funct         (funct),
        .opcode        (opcode),
        .alu_ctrl      (dec_alu_ctrl),
        .funct_illegal (funct_illegal)
    );

    always_comb begin
        state_nxt       = S_FETCH;
        c_reg_write     = 1'b0;
        c_pc_write      = 1'b0;
        c_pc_write_cond = 1'b0;
        c_pc_src        = 2'd0;
        c_i_or_d        = 1'b0;
        c_mem_read      = 1'b0;
        c_mem_write     = 1'b0;
        c_ir_write      = 1'b0;
        c_mem_to_reg    = 1'b0;
        c_alu_src_a     = 1'b0;
        c_alu_src_b     = 2'd0;
        c_illegal       = 1'b0;
        case (state)
            S_FETCH: begin
                c_mem_read  = 1'b1;
                c_ir_write  = 1'b1;
                c_alu_src_b = 2'd1;
                c_pc_write  = 1'b1;
                state_nxt   = S_DECODE;
            end
            S_DECODE: begin
                c_alu_src_b = 2'd3;
                case (opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXEC;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    default: begin
`ifdef MIPS_CTRL_IMM_OPS_EN
                        if (is_imm_op(opcode)) begin
                            state_nxt = S_IMMEXEC;
                        end else begin
                            c_illegal = 1'b1;
                        end
`else
                        c_illegal = 1'b1;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                c_alu_src_a = 1'b1;
                c_alu_src_b = 2'd2;
                if (opcode == OP_LW)      state_nxt = S_MEMRD;
                else if (opcode == OP_SW) state_nxt = S_MEMWR;
            end
            S_MEMRD: begin
                c_mem_read = 1'b1;
                c_i_or_d   = 1'b1;
                state_nxt  = S_MEMWB;
            end
            S_MEMWB: begin
                c_reg_write  = 1'b1;
                c_mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c_mem_write = 1'b1;
                c_i_or_d    = 1'b1;
            end
            S_EXEC: begin
                c_alu_src_a = 1'b1;
                if (funct_illegal) c_illegal = 1'b1;
                else               state_nxt = S_ALUWB;
            end
            S_ALUWB: c_reg_write = 1'b1;
            S_BRANCH: begin
                c_alu_src_a     = 1'b1;
                c_pc_write_cond = 1'b1;
                c_pc_src        = 2'd1;
            end
            S_JUMP: begin
                c_pc_write = 1'b1;
                c_pc_src   = 2'd2;
            end
`ifdef MIPS_CTRL_IMM_OPS_EN
            S_IMMEXEC: begin
                c_alu_src_a = 1'b1;
                c_alu_src_b = 2'd2;
                state_nxt   = S_IMMWB;
            end
            S_IMMWB: begin
                c_alu_src_a = 1'b1;
                c_alu_src_b = 2'd2;
                c_reg_write = 1'b1;
            end
`endif
            default: state_nxt = S_FETCH;
        endcase
    end

    // rst_n gates every strobe so nothing is driven while reset is held,
    // even though the state register already sits in FETCH.
    always_comb begin
        reg_write     = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'd0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_ctrl      = 4'd0;
        illegal       = 1'b0;
        if (rst_n) begin
            reg_write     = c_reg_write;
            pc_write      = c_pc_write;
            pc_write_cond = c_pc_write_cond;
            pc_src        = c_pc_src;
            i_or_d        = c_i_or_d;
            mem_read      = c_mem_read;
            mem_write     = c_mem_write;
            ir_write      = c_ir_write;
            mem_to_reg    = c_mem_to_reg;
            alu_src_a     = c_alu_src_a;
            alu_src_b     = c_alu_src_b;
            alu_ctrl      = dec_alu_ctrl;
            illegal       = c_illegal;
        end
    end

    assign pc_en     = pc_write | (pc_write_cond & alu_zero);
    assign rs        = ir[21 +: RF_ADDR_W];
    assign rt        = ir[16 +: RF_ADDR_W];
    assign write_reg = (opcode == OP_RTYPE) ? ir[11 +: RF_ADDR_W] : ir[16 +: RF_ADDR_W];
    assign state_o   = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed vector table, mid-instruction
// resets and randomized instructions checked against a phase-list reference model.
module tb_mips_multicycle_ctrl;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        alu_zero = 1'b0;

    logic [4:0] rs, rt, write_reg;
    logic       reg_write, pc_write, pc_write_cond, pc_en, i_or_d;
    logic       mem_read, mem_write, ir_write, mem_to_reg, alu_src_a, illegal;
    logic [1:0] pc_src, alu_src_b;
    logic [3:0] alu_ctrl, state_o;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.RF_ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .alu_zero(alu_zero),
        .rs(rs), .rt(rt), .write_reg(write_reg), .reg_write(reg_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_en(pc_en),
        .pc_src(pc_src), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .illegal(illegal), .state_o(state_o)
    );

    typedef struct packed {
        logic [3:0] state;
        logic       reg_write, mem_write, mem_read, ir_write;
        logic       pc_write, pc_write_cond, pc_en, illegal;
        logic       i_or_d, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b, pc_src;
        logic [3:0] alu_ctrl;
        logic [4:0] rs, rt, write_reg;
    } obs_t;

    typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                  P_EXEC, P_ALUWB, P_BRANCH, P_JUMP, P_IMMEXEC, P_IMMWB} phase_t;

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        int          abort_at;
        string       name;
    } vec_t;

    obs_t   act;
    int     checks = 0;
    int     errors = 0;
    phase_t plan[8];
    int     plan_len;

    assign act = {state_o, reg_write, mem_write, mem_read, ir_write, pc_write, pc_write_cond,
                  pc_en, illegal, i_or_d, mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_ctrl,
                  rs, rt, write_reg};

    function automatic bit imm_enabled();
`ifdef MIPS_CTRL_IMM_OPS_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit funct_code(input logic [5:0] fn, output logic [3:0] code);
        code = 4'd0;
        case (fn)
            6'h20: begin code = 4'b0010; return 1'b1; end
            6'h22: begin code = 4'b0110; return 1'b1; end
            6'h24: begin code = 4'b0000; return 1'b1; end
            6'h25: begin code = 4'b0001; return 1'b1; end
            6'h2A: begin code = 4'b0111; return 1'b1; end
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit is_imm(input logic [5:0] op);
        return op == 6'h08 || op == 6'h0C || op == 6'h0D || op == 6'h0A;
    endfunction

    function automatic logic [3:0] imm_code(input logic [5:0] op);
        if (op == 6'h0C) return 4'b0000;
        if (op == 6'h0D) return 4'b0001;
        if (op == 6'h0A) return 4'b0111;
        return 4'b0010;
    endfunction

    // Instruction -> list of control phases it walks through.
    task automatic plan_instr(input logic [31:0] ins);
        logic [5:0] op;
        logic [3:0] c;
        op = ins[31:26];
        plan[0] = P_FETCH;
        plan[1] = P_DECODE;
        plan_len = 2;
        if (op == 6'h00) begin
            plan[2] = P_EXEC;
            plan_len = 3;
            if (funct_code(ins[5:0], c)) begin plan[3] = P_ALUWB; plan_len = 4; end
        end else if (op == 6'h23) begin
            plan[2] = P_MEMADR; plan[3] = P_MEMRD; plan[4] = P_MEMWB; plan_len = 5;
        end else if (op == 6'h2B) begin
            plan[2] = P_MEMADR; plan[3] = P_MEMWR; plan_len = 4;
        end else if (op == 6'h04) begin
            plan[2] = P_BRANCH; plan_len = 3;
        end else if (op == 6'h02) begin
            plan[2] = P_JUMP; plan_len = 3;
        end else if (is_imm(op) && imm_enabled()) begin
            plan[2] = P_IMMEXEC; plan[3] = P_IMMWB; plan_len = 4;
        end
    endtask

    function automatic void expect_phase(input phase_t p, input logic [31:0] ins, input logic zero,
                                         output obs_t e, output obs_t m);
        logic [5:0] op;
        logic [3:0] c;
        op = ins[31:26];
        e = '0;
        m = '0;
        m.state = '1;
        {m.reg_write, m.mem_write, m.mem_read, m.ir_write} = '1;
        {m.pc_write, m.pc_write_cond, m.pc_en, m.illegal} = '1;
        if (p != P_FETCH) begin
            {m.rs, m.rt, m.write_reg} = '1;
            e.rs = ins[25:21];
            e.rt = ins[20:16];
            e.write_reg = (op == 6'h00) ? ins[15:11] : ins[20:16];
        end
        case (p)
            P_FETCH: begin
                e.state = S_FETCH;
                e.mem_read = 1; e.ir_write = 1; e.pc_write = 1; e.pc_en = 1;
                e.alu_src_b = 2'd1; e.alu_ctrl = 4'b0010;
                {m.alu_src_a, m.alu_src_b, m.alu_ctrl, m.pc_src, m.i_or_d} = '1;
            end
            P_DECODE: begin
                e.state = S_DECODE;
                e.alu_src_b = 2'd3; e.alu_ctrl = 4'b0010;
                {m.alu_src_a, m.alu_src_b, m.alu_ctrl} = '1;
                e.illegal = !(op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 ||
                              op == 6'h02 || (is_imm(op) && imm_enabled()));
            end
            P_MEMADR: begin
                e.state = S_MEMADR;
                e.alu_src_a = 1; e.alu_src_b = 2'd2; e.alu_ctrl = 4'b0010;
                {m.alu_src_a, m.alu_src_b, m.alu_ctrl} = '1;
            end
            P_MEMRD: begin
                e.state = S_MEMRD; e.mem_read = 1; e.i_or_d = 1; m.i_or_d = 1;
            end
            P_MEMWB: begin
                e.state = S_MEMWB; e.reg_write = 1; e.mem_to_reg = 1; m.mem_to_reg = 1;
            end
            P_MEMWR: begin
                e.state = S_MEMWR; e.mem_write = 1; e.i_or_d = 1; m.i_or_d = 1;
            end
            P_EXEC: begin
                e.state = S_EXEC;
                e.alu_src_a = 1; e.alu_src_b = 2'd0;
                {m.alu_src_a, m.alu_src_b} = '1;
                if (funct_code(ins[5:0], c)) begin e.alu_ctrl = c; m.alu_ctrl = '1; end
                else e.illegal = 1;
            end
            P_ALUWB: begin
                e.state = S_ALUWB; e.reg_write = 1; e.mem_to_reg = 0; m.mem_to_reg = 1;
            end
            P_BRANCH: begin
                e.state = S_BRANCH;
                e.alu_src_a = 1; e.alu_src_b = 2'd0; e.alu_ctrl = 4'b0110;
                e.pc_write_cond = 1; e.pc_src = 2'd1; e.pc_en = zero;
                {m.alu_src_a, m.alu_src_b, m.alu_ctrl, m.pc_src} = '1;
            end
            P_JUMP: begin
                e.state = S_JUMP; e.pc_write = 1; e.pc_en = 1; e.pc_src = 2'd2; m.pc_src = '1;
            end
            P_IMMEXEC: begin
                e.state = S_IMMEXEC;
                e.alu_src_a = 1; e.alu_src_b = 2'd2; e.alu_ctrl = imm_code(op);
                {m.alu_src_a, m.alu_src_b, m.alu_ctrl} = '1;
            end
            P_IMMWB: begin
                e.state = S_IMMWB; e.reg_write = 1; e.mem_to_reg = 0; e.alu_src_b = 2'd2;
                {m.mem_to_reg, m.alu_src_b} = '1;
            end
            default: e.state = S_FETCH;
        endcase
    endfunction

    task automatic check(input string name, input obs_t e, input obs_t m);
        logic [$bits(obs_t)-1:0] av, ev, mv;
        av = act; ev = e; mv = m;
        checks++;
        if (((av ^ ev) & mv) != '0) begin
            errors++;
            $display("FAIL %s actual=%h required=%h mask=%h", name, av, ev, mv);
        end
    endtask

    // Entered and left at posedge+1; abort_at drops rst_n in that cycle of the instruction.
    task automatic run_instr(input logic [31:0] ins, input logic zero, input int abort_at,
                             input string tag);
        obs_t e, m, ones;
        ones = '1;
        plan_instr(ins);
        for (int k = 0; k < plan_len; k++) begin
            mem_rdata = (k == 0) ? ins : $urandom;
            alu_zero  = zero;
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check($sformatf("%s/abort", tag), '0, ones);
                @(posedge clk);
                #1;
                check($sformatf("%s/held", tag), '0, ones);
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            expect_phase(plan[k], ins, zero, e, m);
            check($sformatf("%s/c%0d/%s", tag, k, plan[k].name()), e, m);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vec_t       vecs[$];
        obs_t       ones;
        logic [5:0] ops[10];
        logic [5:0] fns[5];
        ones = '1;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h3F};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

        vecs.push_back('{32'h012A4020, 1'b0, -1, "add"});
        vecs.push_back('{32'h8D280004, 1'b1, -1, "lw"});
        vecs.push_back('{32'hAD280004, 1'b0, -1, "sw"});
        vecs.push_back('{32'h11090003, 1'b1, -1, "beq_taken"});
        vecs.push_back('{32'h11090003, 1'b0, -1, "beq_not"});
        vecs.push_back('{32'h08000010, 1'b1, -1, "j"});
        vecs.push_back('{32'hFC000000, 1'b1, -1, "bad_op"});
        vecs.push_back('{32'h012A403F, 1'b0, -1, "bad_funct"});
        vecs.push_back('{32'h01495022, 1'b0, -1, "sub"});
        vecs.push_back('{32'h01495024, 1'b0, -1, "and"});
        vecs.push_back('{32'h01495025, 1'b0, -1, "or"});
        vecs.push_back('{32'h0149502A, 1'b0, -1, "slt"});
        vecs.push_back('{32'h2128FFFF, 1'b0, -1, "addi"});
        vecs.push_back('{32'h3128000F, 1'b0, -1, "andi"});
        vecs.push_back('{32'h3528000F, 1'b0, -1, "ori"});
        vecs.push_back('{32'h2928FFFF, 1'b0, -1, "slti"});
        vecs.push_back('{32'hAD280004, 1'b1, 3, "sw_rst_memwr"});
        vecs.push_back('{32'h012A4020, 1'b1, 3, "add_rst_aluwb"});
        vecs.push_back('{32'h8D280004, 1'b0, -1, "lw_after_rst"});

        rst_n     = 1'b0;
        alu_zero  = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset", '0, ones);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[i]) run_instr(vecs[i].instr, vecs[i].zero, vecs[i].abort_at, vecs[i].name);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] ins;
            logic [5:0]  op;
            int          ab;
            ins = $urandom;
            op  = ops[$urandom_range(0, 9)];
            if (op == 6'h3F) op = 6'($urandom);
            ins[31:26] = op;
            if (op == 6'h00 && $urandom_range(0, 9) < 8) ins[5:0] = fns[$urandom_range(0, 4)];
            ab = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 4) : -1;
            run_instr(ins, 1'($urandom), ab, $sformatf("rnd%0d_%h", n, ins));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
